// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline (master) and the branch predictor (slave).
// Optional statistics outputs exist only when BP_STATS_EN is defined.
interface branch_predictor_if;
    // Handshake: upd_valid qualifies every upd_* field in the cycle it is high.
    // There is no ready; the predictor accepts one resolved branch per cycle.
    // The if_pc lookup is unqualified and is answered combinationally every cycle.
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
`ifdef BP_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
`ifdef BP_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, read-before-write.
// Define BP_STATS_EN to add resolved-branch and mispredict counters.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] ALLOC_CTR  = 2'b10
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]      lk_tag, upd_tag;
    logic                  lk_hit, upd_hit, upd_en, taken_w, mispredict_w;

    assign lk_idx  = bp.if_pc[INDEX_BITS+1:2];
    assign lk_tag  = bp.if_pc[31:INDEX_BITS+2];
    assign upd_idx = bp.upd_pc[INDEX_BITS+1:2];
    assign upd_tag = bp.upd_pc[31:INDEX_BITS+2];

    // Word-aligned PCs: the low two bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign taken_w = lk_hit && ctr_q[lk_idx][1];

    assign bp.pred_taken  = taken_w;
    assign bp.pred_target = taken_w ? target_q[lk_idx] : bp.if_pc + 32'd4;

    assign mispredict_w = bp.upd_valid &&
                          ((bp.upd_taken != bp.upd_pred_taken) ||
                           (bp.upd_taken && bp.upd_pred_taken &&
                            (bp.upd_target != bp.upd_pred_target)));
    assign bp.mispredict  = mispredict_w;
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

    // An update arriving together with reset is discarded.
    assign upd_en  = bp.upd_valid && !reset;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        ctr_d    = ctr_q;
        target_d = target_q;
        if (upd_en) begin
            if (upd_hit) begin
                if (bp.upd_taken) begin
                    ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    target_d[upd_idx] = bp.upd_target;
                end else begin
                    ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                ctr_d[upd_idx]    = ALLOC_CTR;
                target_d[upd_idx] = bp.upd_target;
            end
        end
    end

    // Only the valid bits need clearing; stale ctr/target are unreachable until reallocated.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q    <= tag_d;
        ctr_q    <= ctr_d;
        target_q <= target_d;
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bp.upd_valid) stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict_w) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule
